// File: rtl/tour_pkg.sv
// ----------------------------------------------------------------------------
// tour_pkg
// Shared constants and types for the knight's-tour command sequencer.
//   - Command opcodes (cmd[15:12])
//   - Headings (cmd[11:4])
//   - Response bytes returned to the UART
//   - Sequencer state encoding
// ----------------------------------------------------------------------------
package tour_pkg;

    // Command opcodes
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    // Headings
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Response bytes
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VERT   = 3'd1,
        ST_WAIT_V = 3'd2,
        ST_HORZ   = 3'd3,
        ST_WAIT_H = 3'd4
    } tour_state_t;

endpackage

// File: rtl/tour_move_decode.sv
// ----------------------------------------------------------------------------
// tour_move_decode
// Combinational decode of one knight move into its two movement commands.
// Ports:
//   i_move      in  8   one-hot knight move (lowest set bit wins)
//   o_vert_cmd  out 16  vertical leg   {OP_MOVE,    N/S, |dy|}
//   o_horz_cmd  out 16  horizontal leg {OP_FANFARE, E/W, |dx|}
// ----------------------------------------------------------------------------
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  i_move,
    output logic [15:0] o_vert_cmd,
    output logic [15:0] o_horz_cmd
);

    logic       w_dy_pos;
    logic [3:0] w_dy_mag;
    logic       w_dx_pos;
    logic [3:0] w_dx_mag;

    // Priority decode: the lowest set bit selects the move. An all-zero move
    // yields zero displacement, which still produces two (zero-square) legs
    // headed S and W.
    always_comb begin
        w_dy_pos = 1'b0;
        w_dy_mag = 4'd0;
        w_dx_pos = 1'b0;
        w_dx_mag = 4'd0;
        casez (i_move)
            8'b???????1: begin w_dx_pos = 1'b1; w_dx_mag = 4'd1; w_dy_pos = 1'b1; w_dy_mag = 4'd2; end
            8'b??????10: begin w_dx_pos = 1'b0; w_dx_mag = 4'd1; w_dy_pos = 1'b1; w_dy_mag = 4'd2; end
            8'b?????100: begin w_dx_pos = 1'b0; w_dx_mag = 4'd2; w_dy_pos = 1'b1; w_dy_mag = 4'd1; end
            8'b????1000: begin w_dx_pos = 1'b0; w_dx_mag = 4'd2; w_dy_pos = 1'b0; w_dy_mag = 4'd1; end
            8'b???10000: begin w_dx_pos = 1'b0; w_dx_mag = 4'd1; w_dy_pos = 1'b0; w_dy_mag = 4'd2; end
            8'b??100000: begin w_dx_pos = 1'b1; w_dx_mag = 4'd1; w_dy_pos = 1'b0; w_dy_mag = 4'd2; end
            8'b?1000000: begin w_dx_pos = 1'b1; w_dx_mag = 4'd2; w_dy_pos = 1'b0; w_dy_mag = 4'd1; end
            8'b10000000: begin w_dx_pos = 1'b1; w_dx_mag = 4'd2; w_dy_pos = 1'b1; w_dy_mag = 4'd1; end
            default:     begin w_dx_pos = 1'b0; w_dx_mag = 4'd0; w_dy_pos = 1'b0; w_dy_mag = 4'd0; end
        endcase
    end

    assign o_vert_cmd = {OP_MOVE,    (w_dy_pos ? HDG_N : HDG_S), w_dy_mag};
    assign o_horz_cmd = {OP_FANFARE, (w_dx_pos ? HDG_E : HDG_W), w_dx_mag};

endmodule

// File: rtl/tour_cmd.sv
// ----------------------------------------------------------------------------
// tour_cmd
// Tour command sequencer between the knight's-tour solver and the command
// processor. After start_tour it walks NUM_MOVES stored moves, issuing a
// vertical then a horizontal command for each through the cmd/cmd_rdy
// handshake. While idle it passes UART commands straight through.
// Ports:
//   clk               in  1   system clock
//   rst_n             in  1   asynchronous active-low reset
//   start_tour        in  1   solver done pulse, starts the tour
//   move              in  8   one-hot move for index mv_indx
//   mv_indx           out 5   move index presented to the solver
//   cmd_UART          in  16  command from UART wrapper
//   cmd_rdy_UART      in  1   UART command valid
//   clr_cmd_rdy_UART  out 1   clear back to UART wrapper
//   cmd               out 16  command to command processor
//   cmd_rdy           out 1   command valid
//   clr_cmd_rdy       in  1   command processor accepted cmd
//   send_resp         in  1   command processor finished cmd
//   resp              out 8   response byte to UART
// ----------------------------------------------------------------------------
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    tour_state_t r_state;
    tour_state_t w_nxt_state;
    logic [4:0]  r_mv_indx;
    logic        w_last_move;
    logic [15:0] w_vert_cmd;
    logic [15:0] w_horz_cmd;

    tour_move_decode u_decode (
        .i_move     (move),
        .o_vert_cmd (w_vert_cmd),
        .o_horz_cmd (w_horz_cmd)
    );

    assign w_last_move = (r_mv_indx == LAST_INDX);

    // Next-state logic. clr_cmd_rdy is only honoured while a command is
    // offered, send_resp only while waiting for completion.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE:   if (start_tour)  w_nxt_state = ST_VERT;
            ST_VERT:   if (clr_cmd_rdy) w_nxt_state = ST_WAIT_V;
            ST_WAIT_V: if (send_resp)   w_nxt_state = ST_HORZ;
            ST_HORZ:   if (clr_cmd_rdy) w_nxt_state = ST_WAIT_H;
            ST_WAIT_H: if (send_resp)   w_nxt_state = w_last_move ? ST_IDLE : ST_VERT;
            default:                    w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mv_indx <= 5'd0;
        end else begin
            r_state <= w_nxt_state;
            // Index clears on tour start and saturates at the last move.
            if (r_state == ST_IDLE && start_tour) begin
                r_mv_indx <= 5'd0;
            end else if (r_state == ST_WAIT_H && send_resp && !w_last_move) begin
                r_mv_indx <= r_mv_indx + 5'd1;
            end
        end
    end

    assign mv_indx = r_mv_indx;

    // Output muxing: UART passthrough in IDLE, decoded legs otherwise.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            ST_VERT: begin
                cmd     = w_vert_cmd;
                cmd_rdy = 1'b1;
            end
            ST_WAIT_V: begin
                cmd     = w_vert_cmd;
                cmd_rdy = 1'b0;
            end
            ST_HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
            end
            ST_WAIT_H: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b0;
            end
            default: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
        endcase
    end

    assign resp = (r_state == ST_WAIT_H && w_last_move) ? RESP_DONE : RESP_ACK;

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;

    localparam int NM = 24;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move_drv;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    // Handshake drivers: manual (main sequence) and automatic (command processor model)
    logic man_clr, man_resp, cp_clr, cp_resp;
    assign clr_cmd_rdy = man_clr | cp_clr;
    assign send_resp   = man_resp | cp_resp;

    logic cp_auto, stop_at7, stop_reached;

    logic [7:0] moves [NM];

    int checks, errors;
    logic [15:0] exp_q [$];

    // Monitor-side tour model
    logic tour_active;
    int   hs_cnt, tours_done, last_tour_hs, done_resp_cycles;

    tour_cmd #(.NUM_MOVES(NM)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move_drv),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Solver model: presents the stored move for the requested index
    always_comb begin
        int k;
        k = int'(mv_indx);
        move_drv = (k < NM) ? moves[k] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: knight displacement table -> command words
    function automatic void ref_cmds(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
        int dxt [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int dyt [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int b, dx, dy, adx, ady;
        b = -1;
        for (int k = 7; k >= 0; k--) if (m[k]) b = k;
        dx = (b >= 0) ? dxt[b] : 0;
        dy = (b >= 0) ? dyt[b] : 0;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        v = {4'h2, ((dy > 0) ? 8'h00 : 8'h7F), 4'(ady)};
        h = {4'h3, ((dx > 0) ? 8'hBF : 8'h3F), 4'(adx)};
    endfunction

    task automatic push_tour();
        logic [15:0] v, h;
        for (int i = 0; i < NM; i++) begin
            ref_cmds(moves[i], v, h);
            exp_q.push_back(v);
            exp_q.push_back(h);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted command and the response byte
    initial begin : monitor
        logic [15:0] e;
        tour_active = 1'b0;
        hs_cnt = 0; tours_done = 0; last_tour_hs = 0; done_resp_cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tour_active = 1'b0;
                hs_cnt = 0;
            end else begin
                chk("resp", {24'd0, resp}, {24'd0, ((tour_active && hs_cnt == 2*NM) ? 8'h5A : 8'hA5)});
                if (resp == 8'h5A) done_resp_cycles++;
                if (!tour_active && start_tour) begin
                    tour_active = 1'b1;
                    hs_cnt = 0;
                end else if (tour_active && hs_cnt == 2*NM && send_resp) begin
                    tour_active = 1'b0;
                    last_tour_hs = hs_cnt;
                    tours_done++;
                end
                if (cmd_rdy && clr_cmd_rdy) begin
                    if (tour_active) hs_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_handshake", {16'd0, cmd}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hs_cmd", {16'd0, cmd}, {16'd0, e});
                    end
                end
            end
        end
    end

    // Command processor model: accepts offered commands after random delays
    initial begin : cmd_proc
        cp_clr = 1'b0;
        cp_resp = 1'b0;
        stop_reached = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cp_auto && cmd_rdy) begin
                if (stop_at7 && mv_indx == 5'd7 && cmd[15:12] == 4'h3) begin
                    stop_reached = 1'b1;
                end else begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    cp_clr = 1'b1;
                    @(posedge clk); #1;
                    cp_clr = 1'b0;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    cp_resp = 1'b1;
                    @(posedge clk); #1;
                    cp_resp = 1'b0;
                end
            end
        end
    end

    initial begin : main
        logic [15:0] held;
        logic        stable;
        int          n;
        checks = 0; errors = 0;
        rst_n = 1'b0; start_tour = 1'b0; man_clr = 1'b0; man_resp = 1'b0;
        cp_auto = 1'b0; stop_at7 = 1'b0;
        cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0;
        for (int i = 0; i < NM; i++) moves[i] = 8'h00;

        // Reset state
        #1;
        chk("rst_mv_indx", {27'd0, mv_indx}, 32'd0);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_cmd", {16'd0, cmd}, 32'h0000_BEEF);
        chk("rst_resp", {24'd0, resp}, 32'h0000_00A5);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // IDLE passthrough
        cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1;
        tick();
        chk("idle_cmd", {16'd0, cmd}, 32'h0000_2004);
        chk("idle_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        exp_q.push_back(16'h2004);
        man_clr = 1'b1;
        #1;
        chk("idle_clr_uart_hi", {31'd0, clr_cmd_rdy_UART}, 32'd1);
        tick();
        man_clr = 1'b0; cmd_rdy_UART = 1'b0;
        #1;
        chk("idle_clr_uart_lo", {31'd0, clr_cmd_rdy_UART}, 32'd0);
        chk("idle_cmd_rdy_lo", {31'd0, cmd_rdy}, 32'd0);
        cmd_UART = 16'h1234;

        // Tour A: all eight move bits, multi-hot and zero moves
        for (int i = 0; i < 8; i++) moves[i] = 8'h01 << i;
        for (int i = 8; i < NM; i++) moves[i] = 8'h01 << $urandom_range(0, 7);
        moves[20] = 8'h00;
        moves[21] = 8'hA0;
        moves[22] = 8'hFF;
        push_tour();
        n = tours_done;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        chk("a_v0_cmd", {16'd0, cmd}, 32'h0000_2002);
        chk("a_v0_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("a_v0_indx", {27'd0, mv_indx}, 32'd0);
        man_clr = 1'b1; tick(); man_clr = 1'b0;
        chk("a_wv_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("a_wv_cmd", {16'd0, cmd}, 32'h0000_2002);
        man_resp = 1'b1; tick(); man_resp = 1'b0;
        chk("a_h0_cmd", {16'd0, cmd}, 32'h0000_3BF1);
        chk("a_h0_rdy", {31'd0, cmd_rdy}, 32'd1);
        man_clr = 1'b1; tick(); man_clr = 1'b0;
        chk("a_wh_rdy", {31'd0, cmd_rdy}, 32'd0);
        man_resp = 1'b1; tick(); man_resp = 1'b0;
        chk("a_indx1", {27'd0, mv_indx}, 32'd1);

        // Handshake stall in VERT with a stray start_tour
        held = cmd;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start_tour = (i == 10);
            tick();
            if (!cmd_rdy || cmd !== held) stable = 1'b0;
        end
        start_tour = 1'b0;
        chk("stall_stable", {31'd0, stable}, 32'd1);
        chk("stall_indx", {27'd0, mv_indx}, 32'd1);

        cp_auto = 1'b1;
        for (int i = 0; i < 3000 && tours_done == n; i++) tick();
        chk("a_tour_done", tours_done, n + 1);
        chk("a_handshakes", last_tour_hs, 2*NM);
        tick();
        chk("a_end_indx", {27'd0, mv_indx}, 32'd23);
        chk("a_end_rdy", {31'd0, cmd_rdy}, {31'd0, cmd_rdy_UART});
        chk("a_end_cmd", {16'd0, cmd}, 32'h0000_1234);
        chk("a_q_empty", exp_q.size(), 0);
        chk("a_done_seen", {31'd0, (done_resp_cycles > 0)}, 32'd1);

        // Tour B: random one-hot, reset in HORZ at index 7
        for (int i = 0; i < NM; i++) moves[i] = 8'h01 << $urandom_range(0, 7);
        push_tour();
        stop_at7 = 1'b1;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int i = 0; i < 3000 && !stop_reached; i++) tick();
        chk("b_reached7", {31'd0, stop_reached}, 32'd1);
        cp_auto = 1'b0;
        chk("b_indx7", {27'd0, mv_indx}, 32'd7);
        cmd_UART = 16'h2123; cmd_rdy_UART = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("b_rst_indx", {27'd0, mv_indx}, 32'd0);
        chk("b_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("b_rst_cmd", {16'd0, cmd}, 32'h0000_2123);
        chk("b_rst_resp", {24'd0, resp}, 32'h0000_00A5);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("b_post_indx", {27'd0, mv_indx}, 32'd0);
        chk("b_post_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("b_post_cmd", {16'd0, cmd}, 32'h0000_2123);
        cmd_rdy_UART = 1'b0;
        tick();
        chk("b_post_rdy_lo", {31'd0, cmd_rdy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
